// File: rtl/team_06_pkg.sv
// team_06_pkg: shared types, widths and the saturating step helper for the volume controller.
package team_06_pkg;

    localparam int VOL_W = 4;
    localparam logic [VOL_W-1:0] VOL_MAX = 4'd15;

    typedef enum logic [1:0] {
        UNMUTED,
        FADE_OUT,
        MUTED,
        FADE_IN
    } mute_state_t;

    // Up and down together cancel; both ends saturate.
    function automatic logic [VOL_W-1:0] sat_step(
        input logic [VOL_W-1:0] v,
        input logic             up,
        input logic             dn
    );
        return (up && !dn && v != VOL_MAX) ? v + VOL_W'(1) :
               (dn && !up && v != '0)      ? v - VOL_W'(1) : v;
    endfunction

endpackage

// File: rtl/team_06_btn_debounce.sv
// team_06_btn_debounce: synchronizer, debouncer, press-edge step and optional hold auto-repeat.
module team_06_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_RATE     = 1024,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    input  logic clr_repeat,
    output logic step
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);

    logic          sync1_q, sync2_q;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_phase_q, rpt_phase_d;
    logic          step_q, step_d;
    logic          db_flip, rpt_fire, rpt_run;
    logic [RW-1:0] rpt_period;

    always_comb begin
        db_flip     = (sync2_q != lvl_q) && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
        db_cnt_d    = (sync2_q != lvl_q && !db_flip) ? db_cnt_q + DW'(1) : '0;
        lvl_d       = lvl_q ^ db_flip;
        // First repeat waits REPEAT_DELAY after the press step, later ones REPEAT_RATE.
        rpt_run     = REPEAT_EN && lvl_q && !clr_repeat && !db_flip;
        rpt_period  = rpt_phase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
        rpt_fire    = rpt_run && (rpt_cnt_q == rpt_period - RW'(1));
        rpt_cnt_d   = (!rpt_run || rpt_fire) ? '0 : rpt_cnt_q + RW'(1);
        rpt_phase_d = rpt_run && (rpt_phase_q || rpt_fire);
        step_d      = (db_flip && !lvl_q) || rpt_fire;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            lvl_q       <= 1'b0;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            step_q      <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/team_06_volume_controller.sv
// team_06_volume_controller: button-driven volume code with soft mute/unmute fades for the shifter.
module team_06_volume_controller
    import team_06_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               REPEAT_DELAY    = 4096,
    parameter int               REPEAT_RATE     = 1024,
    parameter logic [VOL_W-1:0] VOL_DEFAULT     = 4'd8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_mute,
    input  logic             sample_tick,
    input  logic             bypass_req,
    output logic [VOL_W-1:0] volume,
    output logic             enable_volume,
    output logic             muted,
    output logic             vol_changed
);

    mute_state_t      state_q, state_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [VOL_W-1:0] saved_q, saved_d;
    logic             en_q, en_d;
    logic             vc_q, vc_d;
    logic             up_step, dn_step, mute_step, clr_rpt;

    assign clr_rpt = up_step && dn_step;

    team_06_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (1'b1)
    ) u_up (
        .clk       (clk),
        .nrst      (nrst),
        .btn_raw   (btn_up),
        .clr_repeat(clr_rpt),
        .step      (up_step)
    );

    team_06_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (1'b1)
    ) u_down (
        .clk       (clk),
        .nrst      (nrst),
        .btn_raw   (btn_down),
        .clr_repeat(clr_rpt),
        .step      (dn_step)
    );

    team_06_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .REPEAT_EN      (1'b0)
    ) u_mute (
        .clk       (clk),
        .nrst      (nrst),
        .btn_raw   (btn_mute),
        .clr_repeat(1'b0),
        .step      (mute_step)
    );

    // A mute step always takes priority over a ramp step in the same cycle.
    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        saved_d = saved_q;
        case (state_q)
            UNMUTED: begin
                if (mute_step) begin
                    saved_d = vol_q;
                    state_d = (vol_q == '0) ? MUTED : FADE_OUT;
                end else begin
                    vol_d = sat_step(vol_q, up_step, dn_step);
                end
            end
            FADE_OUT: begin
                if (mute_step) begin
                    state_d = (vol_q == saved_q) ? UNMUTED : FADE_IN;
                end else if (sample_tick) begin
                    vol_d   = vol_q - VOL_W'(1);
                    state_d = (vol_d == '0) ? MUTED : FADE_OUT;
                end
            end
            MUTED: begin
                saved_d = sat_step(saved_q, up_step, dn_step);
                if (mute_step) state_d = (saved_d == '0) ? UNMUTED : FADE_IN;
            end
            FADE_IN: begin
                if (mute_step) begin
                    state_d = (vol_q == '0) ? MUTED : FADE_OUT;
                end else if (sample_tick) begin
                    vol_d   = vol_q + VOL_W'(1);
                    state_d = (vol_d >= saved_q) ? UNMUTED : FADE_IN;
                end
            end
            default: state_d = UNMUTED;
        endcase
        vc_d = (vol_d != vol_q);
        en_d = ~bypass_req;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= UNMUTED;
            vol_q   <= VOL_DEFAULT;
            saved_q <= VOL_DEFAULT;
            en_q    <= 1'b0;
            vc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            saved_q <= saved_d;
            en_q    <= en_d;
            vc_q    <= vc_d;
        end
    end

    assign volume        = vol_q;
    assign enable_volume = en_q;
    assign muted         = (state_q == MUTED);
    assign vol_changed   = vc_q;

endmodule

// File: tb/tb_team_06_volume_controller.sv
// tb_team_06_volume_controller: directed stimulus with a vol_changed-driven scoreboard.
module tb_team_06_volume_controller;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_mute = 1'b0;
    logic       sample_tick = 1'b0;
    logic       bypass_req = 1'b0;
    logic [3:0] volume;
    logic       enable_volume, muted, vol_changed;

    int cyc = 0;
    int passed = 0;
    int total = 0;

    typedef struct {
        int vol;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    team_06_volume_controller #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8),
        .VOL_DEFAULT    (4'd8)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_mute     (btn_mute),
        .sample_tick  (sample_tick),
        .bypass_req   (bypass_req),
        .volume       (volume),
        .enable_volume(enable_volume),
        .muted        (muted),
        .vol_changed  (vol_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int v, input int at);
        exp_t e;
        e.vol = v;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Drive buttons now, hold for 'hold' clocks, release and let the debouncers settle.
    task automatic press(input logic u, input logic d, input logic m, input int hold);
        btn_up   = u;
        btn_down = d;
        btn_mute = m;
        repeat (hold) @(posedge clk);
        #1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mute = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(posedge clk);
            #1;
            sample_tick = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (nrst && vol_changed) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected vol_changed: volume %0d at cycle %0d, expected no change", volume, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("volume at vol_changed", int'(volume), mon_e.vol);
                if (mon_e.at >= 0) check("vol_changed cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expected changes pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // 1. reset state and enable_volume release
        repeat (3) @(posedge clk);
        #1;
        check("reset volume", int'(volume), 8);
        check("reset enable_volume", int'(enable_volume), 0);
        check("reset muted", int'(muted), 0);
        check("reset vol_changed", int'(vol_changed), 0);
        nrst = 1'b1;
        #1 check("enable_volume before first edge", int'(enable_volume), 0);
        @(posedge clk);
        #1 check("enable_volume after release", int'(enable_volume), 1);

        // 2. single press latency, then a glitch shorter than the debounce window
        t0 = cyc;
        push(9, t0 + 7);
        press(1'b1, 1'b0, 1'b0, 10);
        press(1'b1, 1'b0, 1'b0, 3);
        check("glitch ignored", int'(volume), 9);

        nrst = 1'b0;
        #1;
        check("async reset volume", int'(volume), 8);
        check("async reset enable_volume", int'(enable_volume), 0);
        check("async reset muted", int'(muted), 0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1 check("enable_volume after mid-run reset", int'(enable_volume), 1);

        // 3. hold with auto-repeat: press at +7, first repeat at +27, then every 8
        t0 = cyc;
        for (int k = 0; k < 7; k++) push(9 + k, t0 + (k == 0 ? 7 : 27 + 8 * (k - 1)));
        press(1'b1, 1'b0, 1'b0, 200);
        check("saturated at 15", int'(volume), 15);
        t0 = cyc;
        for (int k = 0; k < 15; k++) push(14 - k, t0 + (k == 0 ? 7 : 27 + 8 * (k - 1)));
        press(1'b0, 1'b1, 1'b0, 200);
        check("saturated at 0", int'(volume), 0);

        for (int v = 1; v <= 5; v++) begin
            t0 = cyc;
            push(v, t0 + 7);
            press(1'b1, 1'b0, 1'b0, 10);
        end

        // 4. mute fade down and unmute fade up
        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 4; v >= 0; v--) push(v, -1);
        tick_n(5);
        check("muted after fade out", int'(muted), 1);
        check("volume after fade out", int'(volume), 0);
        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 1; v <= 5; v++) push(v, -1);
        tick_n(5);
        check("unmuted after fade in", int'(muted), 0);
        check("volume after fade in", int'(volume), 5);

        // 5. adjust saved level while muted, then reverse a fade midway
        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 4; v >= 0; v--) push(v, -1);
        tick_n(5);
        press(1'b1, 1'b0, 1'b0, 10);
        press(1'b1, 1'b0, 1'b0, 10);
        check("muted volume held", int'(volume), 0);
        check("still muted after ups", int'(muted), 1);
        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 1; v <= 7; v++) push(v, -1);
        tick_n(7);
        check("unmute to adjusted level", int'(volume), 7);

        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 6; v >= 3; v--) push(v, -1);
        tick_n(4);
        check("mid fade-out volume", int'(volume), 3);
        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 4; v <= 7; v++) push(v, -1);
        tick_n(4);
        tick_n(2);
        check("reversal restored level", int'(volume), 7);
        t0 = cyc;
        push(8, t0 + 7);
        press(1'b1, 1'b0, 1'b0, 10);

        // 6. simultaneous up/down, bypass, reset during fade-in
        press(1'b1, 1'b1, 1'b0, 10);
        check("up+down cancel", int'(volume), 8);
        bypass_req = 1'b1;
        @(posedge clk);
        #1 check("bypass enable_volume", int'(enable_volume), 0);
        check("bypass volume", int'(volume), 8);
        bypass_req = 1'b0;
        @(posedge clk);
        #1 check("bypass off enable_volume", int'(enable_volume), 1);

        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 7; v >= 0; v--) push(v, -1);
        tick_n(8);
        check("muted before reset test", int'(muted), 1);
        press(1'b0, 1'b0, 1'b1, 10);
        for (int v = 1; v <= 3; v++) push(v, -1);
        tick_n(3);
        nrst = 1'b0;
        #1;
        check("reset during fade-in volume", int'(volume), 8);
        check("reset during fade-in muted", int'(muted), 0);
        @(posedge clk);
        #1 nrst = 1'b1;
        tick_n(2);
        check("no ramp after reset", int'(volume), 8);
        t0 = cyc;
        push(9, t0 + 7);
        press(1'b1, 1'b0, 1'b0, 10);

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
